ctrl_multiciclo: RTL and testbench
==================================

// Module: ctrl_multiciclo
// PURPOSE
//  Multicycle sequencer for the nRisc 8-bit core. It steps PC, banco de registradores, ULA and the
//  instruction/data memory ports through BUSCA/DECODE/EXEC/MEM/WB, one instruction at a time.
//  It also waits on memory-ready handshakes and bounds each wait with a timeout.
//  It replaces the single-cycle CTRL decode; datapath muxes and enables are driven from here.
// PARAMETERS
//  WAIT_MAX   15  max cycles a memory request waits for ready before the ERRO state; range 1..255
// PORTS
//  Clock          in   1  rising-edge clock
//  Reset          in   1  synchronous, active-high; clears all state and outputs
//  OPcode         in   3  instruction opcode taken from the IR; 000 ADD 001 SUB 010 ADDI 011 LW 100 SW 101 BEQ 110 J 111 HALT
//  Zero           in   1  ULA zero flag; sampled only in EXEC for BEQ
//  InstPronta     in   1  instruction memory ready
//  MemPronta      in   1  data memory ready
//  LerInst        out  1  instruction fetch request
//  EscIR          out  1  latch Instrucao into the IR
//  EscPC          out  1  PC write enable
//  Jump           out  1  PC source is the jump target
//  Branch         out  1  PC source is the branch target
//  ULAFonte       out  1  0 = register operand, 1 = immediate
//  ULAOp          out  2  00 add, 01 sub, 10 function from OPcode
//  LerMem         out  1  data read request
//  EscMem         out  1  data write request
//  MemToReg       out  1  write-back data comes from memory
//  RegDest        out  1  1 = rd field, 0 = fixed register r0
//  EscReg         out  1  register bank write enable
//  Estado         out  3  state: 0 BUSCA 1 DECODE 2 EXEC 3 MEM 4 WB 5 PARADO 6 ERRO
//  Parado         out  1  core halted by HALT
//  Erro           out  1  memory timeout occurred
//  Retiradas      out  8  retired-instruction count; wraps 255->0
// BEHAVIOUR
//  - Reset: Estado=BUSCA, wait counter=0, Retiradas=0, Parado=Erro=0. All strobes are 0 during the Reset cycle.
//  - Registered state; all strobes are Moore/Mealy combinational from Estado, OPcode, ready inputs and Zero.
//  - BUSCA: LerInst=1. When InstPronta=1: EscIR=1 and EscPC=1 (PC+1) in the same cycle, then go to DECODE.
//    Otherwise the wait counter increments; when counter==WAIT_MAX-1 and ready is still 0, go to ERRO.
//  - DECODE: one cycle; clears the wait counter. HALT -> PARADO. J: Jump=1, EscPC=1, Retiradas+1 -> BUSCA.
//    All other opcodes -> EXEC.
//  - EXEC: ADD ULAOp=10; SUB ULAOp=10; ADDI ULAFonte=1, ULAOp=00; ADD/SUB/ADDI -> WB.
//    LW/SW: ULAFonte=1, ULAOp=00 (address), then go to MEM.
//    BEQ: ULAOp=01, Branch=1, EscPC=Zero; Retiradas+1 -> BUSCA.
//  - MEM: LW holds LerMem=1 until MemPronta, then goes to WB. SW holds EscMem=1 until MemPronta, then
//    Retiradas+1 -> BUSCA. Timeout is the same rule as in BUSCA -> ERRO.
//  - WB: EscReg=1 for exactly one cycle. MemToReg=1 only for LW. RegDest=1 for ADD/SUB, 0 for ADDI/LW.
//    Retiradas+1 -> BUSCA.
//  - PARADO: Parado=1, all strobes 0, held until Reset. ERRO: Erro=1, all strobes 0, held until Reset.
//  - Ready and timeout in the same cycle: ready wins and the transfer completes.
//  - Ready asserted outside its wait state: ignored.
//  - Reset mid-operation (any state, including mid-wait): abandons the instruction; no EscReg/EscMem
//    pulse is issued in that cycle or the next.
//  - Strobe exclusivity: EscReg, EscMem and EscPC are never all asserted together. Jump and Branch are
//    never both 1.
//  - Latency with zero-wait memory: ALU ops 4 cycles, LW 5, SW 4, BEQ 3, J 2.
// TESTING
//  1 Reset, then ADD with InstPronta=1 every cycle -> Estado 0,1,2,4,0. EscReg=1 only in WB,
//    RegDest=1, Retiradas=1.
//  2 LW with MemPronta delayed 3 cycles -> LerMem high exactly 4 cycles in MEM, then WB with MemToReg=1,
//    EscReg=1. Total 8 cycles.
//  3 BEQ with Zero=1, then BEQ with Zero=0 -> EscPC pulse in EXEC only for the first, Branch=1 in both,
//    Retiradas +2.
//  4 InstPronta held 0 with WAIT_MAX=4 -> ERRO after 4 BUSCA cycles, Erro=1. Ready on the 4th cycle
//    instead -> DECODE, no error.
//  5 SW, Reset asserted during the MEM wait -> next cycle Estado=0, EscMem=0, Retiradas=0. HALT -> Parado=1,
//    held for 20 cycles.
//  6 256 J instructions -> Retiradas wraps to 0. Each J takes 2 cycles with Jump=EscPC=1 in DECODE.

Source files
------------

// File: rtl/ctrl_multiciclo.sv
// Multicycle control sequencer for the nRisc 8-bit core.
// Steps BUSCA/DECODE/EXEC/MEM/WB and bounds every memory wait with a timeout.
module ctrl_multiciclo #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [2:0] OPcode,
    input  logic       Zero,
    input  logic       InstPronta,
    input  logic       MemPronta,
    output logic       LerInst,
    output logic       EscIR,
    output logic       EscPC,
    output logic       Jump,
    output logic       Branch,
    output logic       ULAFonte,
    output logic [1:0] ULAOp,
    output logic       LerMem,
    output logic       EscMem,
    output logic       MemToReg,
    output logic       RegDest,
    output logic       EscReg,
    output logic [2:0] Estado,
    output logic       Parado,
    output logic       Erro,
    output logic [7:0] Retiradas
);

    typedef enum logic [2:0] {
        BUSCA  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        PARADO = 3'd5,
        ERRO   = 3'd6
    } estado_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_LW   = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_BEQ  = 3'b101;
    localparam logic [2:0] OP_J    = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [7:0] LIMITE = 8'(WAIT_MAX - 1);

    estado_t    estado, prox;
    logic [7:0] espera, espera_prox;
    logic       retira;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            estado    <= BUSCA;
            espera    <= 8'd0;
            Retiradas <= 8'd0;
        end else begin
            estado <= prox;
            espera <= espera_prox;
            if (retira) Retiradas <= Retiradas + 8'd1;
        end
    end

    always_comb begin
        prox        = estado;
        espera_prox = espera;
        retira      = 1'b0;
        LerInst     = 1'b0;
        EscIR       = 1'b0;
        EscPC       = 1'b0;
        Jump        = 1'b0;
        Branch      = 1'b0;
        ULAFonte    = 1'b0;
        ULAOp       = 2'b00;
        LerMem      = 1'b0;
        EscMem      = 1'b0;
        MemToReg    = 1'b0;
        RegDest     = 1'b0;
        EscReg      = 1'b0;
        Parado      = 1'b0;
        Erro        = 1'b0;
        case (estado)
            BUSCA: begin
                LerInst = 1'b1;
                // ready wins over a timeout landing in the same cycle
                if (InstPronta) begin
                    EscIR       = 1'b1;
                    EscPC       = 1'b1;
                    espera_prox = 8'd0;
                    prox        = DECODE;
                end else if (espera == LIMITE) begin
                    espera_prox = 8'd0;
                    prox        = ERRO;
                end else begin
                    espera_prox = espera + 8'd1;
                end
            end
            DECODE: begin
                espera_prox = 8'd0;
                case (OPcode)
                    OP_HALT: prox = PARADO;
                    OP_J: begin
                        Jump   = 1'b1;
                        EscPC  = 1'b1;
                        retira = 1'b1;
                        prox   = BUSCA;
                    end
                    default: prox = EXEC;
                endcase
            end
            EXEC: begin
                espera_prox = 8'd0;
                case (OPcode)
                    OP_ADD, OP_SUB: begin
                        ULAOp = 2'b10;
                        prox  = WB;
                    end
                    OP_ADDI: begin
                        ULAFonte = 1'b1;
                        prox     = WB;
                    end
                    OP_LW, OP_SW: begin
                        ULAFonte = 1'b1;
                        prox     = MEM;
                    end
                    OP_BEQ: begin
                        ULAOp  = 2'b01;
                        Branch = 1'b1;
                        EscPC  = Zero;
                        retira = 1'b1;
                        prox   = BUSCA;
                    end
                    default: prox = BUSCA;
                endcase
            end
            MEM: begin
                if (OPcode == OP_SW) EscMem = 1'b1;
                else                 LerMem = 1'b1;
                if (MemPronta) begin
                    espera_prox = 8'd0;
                    if (OPcode == OP_SW) begin
                        retira = 1'b1;
                        prox   = BUSCA;
                    end else begin
                        prox = WB;
                    end
                end else if (espera == LIMITE) begin
                    espera_prox = 8'd0;
                    prox        = ERRO;
                end else begin
                    espera_prox = espera + 8'd1;
                end
            end
            WB: begin
                EscReg   = 1'b1;
                MemToReg = (OPcode == OP_LW);
                RegDest  = (OPcode == OP_ADD) || (OPcode == OP_SUB);
                retira   = 1'b1;
                prox     = BUSCA;
            end
            PARADO: Parado = 1'b1;
            ERRO:   Erro   = 1'b1;
            default: prox = BUSCA;
        endcase
        // a reset cycle abandons the instruction with every strobe quiet
        if (Reset) begin
            retira   = 1'b0;
            LerInst  = 1'b0;
            EscIR    = 1'b0;
            EscPC    = 1'b0;
            Jump     = 1'b0;
            Branch   = 1'b0;
            ULAFonte = 1'b0;
            ULAOp    = 2'b00;
            LerMem   = 1'b0;
            EscMem   = 1'b0;
            MemToReg = 1'b0;
            RegDest  = 1'b0;
            EscReg   = 1'b0;
            Parado   = 1'b0;
            Erro     = 1'b0;
        end
    end

    assign Estado = estado;

endmodule

// File: tb/tb_ctrl_multiciclo.sv
// Scoreboard bench for ctrl_multiciclo (WAIT_MAX=4).
// Expected per-cycle outputs are queued at drive time and compared at negedge.
module tb_ctrl_multiciclo;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_LW   = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_BEQ  = 3'b101;
    localparam logic [2:0] OP_J    = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef struct packed {
        logic       li, ir, pc, j, br, uf;
        logic [1:0] op;
        logic       lm, em, m2r, rd, er;
    } strb_t;

    // fields: li ir pc j br uf op lm em m2r rd er
    localparam strb_t NO   = 13'b0_0_0_0_0_0_00_0_0_0_0_0;
    localparam strb_t F0   = 13'b1_0_0_0_0_0_00_0_0_0_0_0;
    localparam strb_t F1   = 13'b1_1_1_0_0_0_00_0_0_0_0_0;
    localparam strb_t DJ   = 13'b0_0_1_1_0_0_00_0_0_0_0_0;
    localparam strb_t EXR  = 13'b0_0_0_0_0_0_10_0_0_0_0_0;
    localparam strb_t EXI  = 13'b0_0_0_0_0_1_00_0_0_0_0_0;
    localparam strb_t EXB1 = 13'b0_0_1_0_1_0_01_0_0_0_0_0;
    localparam strb_t EXB0 = 13'b0_0_0_0_1_0_01_0_0_0_0_0;
    localparam strb_t MLW  = 13'b0_0_0_0_0_0_00_1_0_0_0_0;
    localparam strb_t MSW  = 13'b0_0_0_0_0_0_00_0_1_0_0_0;
    localparam strb_t WBR  = 13'b0_0_0_0_0_0_00_0_0_0_1_1;
    localparam strb_t WBI  = 13'b0_0_0_0_0_0_00_0_0_0_0_1;
    localparam strb_t WBL  = 13'b0_0_0_0_0_0_00_0_0_1_0_1;

    typedef struct {
        string      tag;
        logic       cs;
        logic [2:0] st;
        strb_t      s;
        logic [7:0] ret;
        logic       p, e;
    } exp_t;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [2:0] OPcode;
    logic       Zero, InstPronta, MemPronta;
    logic       LerInst, EscIR, EscPC, Jump, Branch, ULAFonte;
    logic [1:0] ULAOp;
    logic       LerMem, EscMem, MemToReg, RegDest, EscReg;
    logic [2:0] Estado;
    logic       Parado, Erro;
    logic [7:0] Retiradas;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t cur;
    strb_t obs;

    ctrl_multiciclo #(.WAIT_MAX(4)) dut (
        .Clock(Clock), .Reset(Reset), .OPcode(OPcode), .Zero(Zero),
        .InstPronta(InstPronta), .MemPronta(MemPronta),
        .LerInst(LerInst), .EscIR(EscIR), .EscPC(EscPC), .Jump(Jump),
        .Branch(Branch), .ULAFonte(ULAFonte), .ULAOp(ULAOp),
        .LerMem(LerMem), .EscMem(EscMem), .MemToReg(MemToReg),
        .RegDest(RegDest), .EscReg(EscReg), .Estado(Estado),
        .Parado(Parado), .Erro(Erro), .Retiradas(Retiradas)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    assign obs = {LerInst, EscIR, EscPC, Jump, Branch, ULAFonte, ULAOp,
                  LerMem, EscMem, MemToReg, RegDest, EscReg};

    always @(negedge Clock) begin
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            if (cur.cs) chk({cur.tag, ".st"}, 16'(Estado), 16'(cur.st));
            chk({cur.tag, ".strb"}, 16'(obs), 16'(cur.s));
            chk({cur.tag, ".ret"}, 16'(Retiradas), 16'(cur.ret));
            chk({cur.tag, ".pe"}, 16'({Parado, Erro}), 16'({cur.p, cur.e}));
        end
    end

    task automatic cyc(input string tag, input logic rst,
                       input logic [2:0] op, input logic ip, mp, z,
                       input logic [2:0] st, input strb_t s,
                       input logic [7:0] ret, input logic p, e,
                       input logic cs = 1'b1);
        exp_t x;
        Reset      = rst;
        OPcode     = op;
        InstPronta = ip;
        MemPronta  = mp;
        Zero       = z;
        x.tag = tag; x.cs = cs; x.st = st; x.s = s;
        x.ret = ret; x.p = p; x.e = e;
        sb.push_back(x);
        @(posedge Clock);
        #1;
    endtask

    task automatic fetch(input string tag, input logic [2:0] op,
                         input logic [7:0] ret);
        cyc({tag, ".busca"}, 0, op, 1, 0, 0, 3'd0, F1, ret, 0, 0);
    endtask

    task automatic dec(input string tag, input logic [2:0] op,
                       input logic [7:0] ret);
        cyc({tag, ".dec"}, 0, op, 0, 0, 0, 3'd1, NO, ret, 0, 0);
    endtask

    initial begin
        Reset = 1'b1; OPcode = OP_ADD; Zero = 1'b0;
        InstPronta = 1'b0; MemPronta = 1'b0;
        @(posedge Clock);
        #1;
        cyc("reset", 1, OP_ADD, 1, 1, 1, 3'd0, NO, 8'd0, 0, 0);

        // ALU ops: ADD, SUB, ADDI
        fetch("add", OP_ADD, 8'd0);
        dec("add", OP_ADD, 8'd0);
        cyc("add.exec", 0, OP_ADD, 1, 1, 0, 3'd2, EXR, 8'd0, 0, 0);
        cyc("add.wb", 0, OP_ADD, 1, 1, 0, 3'd4, WBR, 8'd0, 0, 0);

        // LW with three not-ready cycles; the 4th hits the timeout edge
        fetch("lw", OP_LW, 8'd1);
        dec("lw", OP_LW, 8'd1);
        cyc("lw.exec", 0, OP_LW, 0, 1, 0, 3'd2, EXI, 8'd1, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc($sformatf("lw.mw%0d", i), 0, OP_LW, 1, 0, 0,
                3'd3, MLW, 8'd1, 0, 0);
        cyc("lw.mrdy", 0, OP_LW, 0, 1, 0, 3'd3, MLW, 8'd1, 0, 0);
        cyc("lw.wb", 0, OP_LW, 0, 0, 0, 3'd4, WBL, 8'd1, 0, 0);

        fetch("beq1", OP_BEQ, 8'd2);
        dec("beq1", OP_BEQ, 8'd2);
        cyc("beq1.exec", 0, OP_BEQ, 0, 0, 1, 3'd2, EXB1, 8'd2, 0, 0);
        fetch("beq0", OP_BEQ, 8'd3);
        dec("beq0", OP_BEQ, 8'd3);
        cyc("beq0.exec", 0, OP_BEQ, 0, 0, 0, 3'd2, EXB0, 8'd3, 0, 0);

        fetch("sub", OP_SUB, 8'd4);
        dec("sub", OP_SUB, 8'd4);
        cyc("sub.exec", 0, OP_SUB, 0, 0, 0, 3'd2, EXR, 8'd4, 0, 0);
        cyc("sub.wb", 0, OP_SUB, 0, 0, 0, 3'd4, WBR, 8'd4, 0, 0);
        fetch("addi", OP_ADDI, 8'd5);
        dec("addi", OP_ADDI, 8'd5);
        cyc("addi.exec", 0, OP_ADDI, 0, 0, 0, 3'd2, EXI, 8'd5, 0, 0);
        cyc("addi.wb", 0, OP_ADDI, 0, 0, 0, 3'd4, WBI, 8'd5, 0, 0);

        // fetch timeout into ERRO
        for (int i = 0; i < 4; i++)
            cyc($sformatf("to.b%0d", i), 0, OP_ADD, 0, 1, 0,
                3'd0, F0, 8'd6, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc($sformatf("to.erro%0d", i), 0, OP_ADD, 1, 1, 0,
                3'd6, NO, 8'd6, 0, 1);
        cyc("to.rst", 1, OP_ADD, 0, 0, 0, 3'd6, NO, 8'd6, 0, 0);

        // ready on the last allowed fetch cycle
        for (int i = 0; i < 3; i++)
            cyc($sformatf("late.b%0d", i), 0, OP_J, 0, 0, 0,
                3'd0, F0, 8'd0, 0, 0);
        cyc("late.b3", 0, OP_J, 1, 0, 0, 3'd0, F1, 8'd0, 0, 0);
        cyc("late.dec", 0, OP_J, 0, 0, 0, 3'd1, DJ, 8'd0, 0, 0);

        fetch("sw", OP_SW, 8'd1);
        dec("sw", OP_SW, 8'd1);
        cyc("sw.exec", 0, OP_SW, 0, 0, 0, 3'd2, EXI, 8'd1, 0, 0);
        cyc("sw.mem", 0, OP_SW, 0, 1, 0, 3'd3, MSW, 8'd1, 0, 0);

        // SW abandoned by reset mid-wait
        fetch("swr", OP_SW, 8'd2);
        dec("swr", OP_SW, 8'd2);
        cyc("swr.exec", 0, OP_SW, 0, 0, 0, 3'd2, EXI, 8'd2, 0, 0);
        cyc("swr.mw0", 0, OP_SW, 0, 0, 0, 3'd3, MSW, 8'd2, 0, 0);
        cyc("swr.mw1", 0, OP_SW, 0, 0, 0, 3'd3, MSW, 8'd2, 0, 0);
        cyc("swr.rst", 1, OP_SW, 0, 0, 0, 3'd3, NO, 8'd2, 0, 0);
        cyc("swr.after", 0, OP_SW, 0, 1, 0, 3'd0, F0, 8'd0, 0, 0);

        fetch("halt", OP_HALT, 8'd0);
        dec("halt", OP_HALT, 8'd0);
        for (int i = 0; i < 20; i++)
            cyc($sformatf("halt.p%0d", i), 0, OP_HALT, 1, 1, 1,
                3'd5, NO, 8'd0, 1, 0);
        cyc("halt.rst", 1, OP_HALT, 0, 0, 0, 3'd5, NO, 8'd0, 0, 0);

        for (int i = 0; i < 256; i++) begin
            fetch($sformatf("j%0d", i), OP_J, 8'(i));
            cyc($sformatf("j%0d.dec", i), 0, OP_J, 0, 0, 0,
                3'd1, DJ, 8'(i), 0, 0);
        end
        cyc("wrap", 0, OP_J, 0, 0, 0, 3'd0, F0, 8'd0, 0, 0);

        @(negedge Clock);
        #1;
        chk("sb_empty", 16'(sb.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
